debug_step_control: RTL and testbench

Run/step/halt controller for the pipeline debug path. It accepts byte commands from the debug host link and drives the clock-enable of every pipeline register. It counts the enabled cycles and hands a snapshot of the fetch-stage `pc` to the downstream debug unit each time the pipeline stops. It sits between the host command receiver (upstream) and the pipeline plus debug PC monitor (downstream).

---
 rtl/debug_pkg.sv | 18 +
 rtl/debug_step_control_counter.sv | 18 +
 rtl/debug_step_control.sv | 109 ++++++++++
 tb/tb_debug_step_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the pipeline debug run/step/halt path.
package debug_pkg;

  localparam int PC_W = 32;

  localparam logic [7:0] CMD_RUN_DEF   = 8'h52;
  localparam logic [7:0] CMD_STEP_DEF  = 8'h53;
  localparam logic [7:0] CMD_HALT_DEF  = 8'h48;
  localparam logic [7:0] CMD_CLEAR_DEF = 8'h43;

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/debug_step_control_counter.sv
// Wrapping enabled-cycle counter with synchronous clear (clear wins over enable).
module debug_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + W'(1);
  end

endmodule

// File: rtl/debug_step_control.sv
// Run/step/halt controller driving the pipeline clock enable and PC trace snapshot.
// Optional breakpoint compare is built with `define DEBUG_BREAKPOINT_EN.
module debug_step_control
  import debug_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter logic [7:0]  CMD_RUN     = CMD_RUN_DEF,
  parameter logic [7:0]  CMD_STEP    = CMD_STEP_DEF,
  parameter logic [7:0]  CMD_HALT    = CMD_HALT_DEF,
  parameter logic [7:0]  CMD_CLEAR   = CMD_CLEAR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [7:0]      cmd_data,
  output logic            cmd_ready,
  input  logic [PC_W-1:0] pc,
`ifdef DEBUG_BREAKPOINT_EN
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_enable,
`endif
  output logic            pipe_en,
  output logic            halted,
  output logic [31:0]     cycle_count,
  output logic            trace_valid,
  output logic [PC_W-1:0] trace_pc,
  input  logic            trace_ready
);

  state_t     state, state_nxt;
  logic [7:0] step_cnt;
  logic       step_ld, cnt_clr, accept, bp_hit;

  assign accept = cmd_valid && cmd_ready;

`ifdef DEBUG_BREAKPOINT_EN
  // Hold the pipeline on the breakpoint PC so that instruction is not fetched past.
  assign bp_hit = (state == ST_RUN) && bp_enable && (pc == bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  assign pipe_en = ((state == ST_RUN) && !bp_hit) || (state == ST_STEP);

  always_comb begin
    state_nxt = state;
    step_ld   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_HALT: begin
        if (accept) begin
          if (cmd_data == CMD_RUN) begin
            state_nxt = ST_RUN;
          end else if (cmd_data == CMD_STEP) begin
            state_nxt = ST_STEP;
            step_ld   = 1'b1;
          end else if (cmd_data == CMD_CLEAR) begin
            cnt_clr   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bp_hit || (accept && cmd_data == CMD_HALT)) state_nxt = ST_REPORT;
      end
      ST_STEP: begin
        if (step_cnt == 8'd1) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (trace_valid && trace_ready) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HALT;
      step_cnt    <= '0;
      cmd_ready   <= 1'b1;
      halted      <= 1'b1;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == ST_HALT) || (state_nxt == ST_RUN);
      halted    <= (state_nxt == ST_HALT);
      if (step_ld)
        step_cnt <= 8'(STEP_CYCLES);
      else if (state == ST_STEP && step_cnt != 8'd0)
        step_cnt <= step_cnt - 8'd1;
      // Snapshot only on the entry edge; trace_pc then holds until the next stop.
      if (state_nxt == ST_REPORT && state != ST_REPORT) begin
        trace_valid <= 1'b1;
        trace_pc    <= pc;
      end else if (state == ST_REPORT && trace_ready) begin
        trace_valid <= 1'b0;
      end
    end
  end

  debug_cycle_counter #(.W(32)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pipe_en),
    .clr   (cnt_clr),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_debug_step_control.sv
// Directed bench for debug_step_control: vector table plus multi-cycle sequences.
module tb_debug_step_control;

  logic        clk = 1'b0;
  logic        rst_n, rst8_n;
  logic        cmd_valid, trace_ready;
  logic [7:0]  cmd_data;
  logic [31:0] pc;
`ifdef DEBUG_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic        bp_enable;
`endif
  logic        cmd_ready, pipe_en, halted, trace_valid;
  logic [31:0] cycle_count, trace_pc;
  logic        cmd_ready8, pipe_en8, halted8, trace_valid8;
  logic [31:0] cycle_count8, trace_pc8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debug_step_control #(.STEP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .pc(pc),
`ifdef DEBUG_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_enable(bp_enable),
`endif
    .pipe_en(pipe_en), .halted(halted), .cycle_count(cycle_count),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_ready(trace_ready)
  );

  debug_step_control #(.STEP_CYCLES(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready8), .pc(pc),
`ifdef DEBUG_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_enable(bp_enable),
`endif
    .pipe_en(pipe_en8), .halted(halted8), .cycle_count(cycle_count8),
    .trace_valid(trace_valid8), .trace_pc(trace_pc8), .trace_ready(trace_ready)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        tr;
    logic        pe, rdy, h, tv;
    logic [31:0] cnt, tpc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic tr);
    cmd_valid   = v;
    cmd_data    = d;
    trace_ready = tr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    tbl[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0};
    tbl[2]  = '{1'b1, 8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'h40};
    tbl[4]  = '{1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'h40};
    tbl[5]  = '{1'b1, 8'h52, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h40};
    tbl[6]  = '{1'b1, 8'h52, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'h40};
    tbl[7]  = '{1'b1, 8'h53, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 32'h40};
    tbl[8]  = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'h40};
    tbl[9]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 32'h40};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'h40};
    tbl[11] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h40};

    rst_n = 1'b0; rst8_n = 1'b0; pc = 32'h40;
`ifdef DEBUG_BREAKPOINT_EN
    bp_addr = 32'h0; bp_enable = 1'b0;
`endif
    drive(1'b0, 8'h00, 1'b0);
    #12;
    chk("rst pipe_en", pipe_en, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst halted", halted, 1'b1);
    chk("rst cycle_count", cycle_count, 32'd0);
    chk("rst trace_valid", trace_valid, 1'b0);
    chk("rst trace_pc", trace_pc, 32'd0);
    tick();
    rst_n = 1'b1;

    // Step, report stall, run with ignored codes, halt, clear.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].tr);
      tick();
      chk($sformatf("vec%0d pipe_en", i), pipe_en, tbl[i].pe);
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("vec%0d halted", i), halted, tbl[i].h);
      chk($sformatf("vec%0d trace_valid", i), trace_valid, tbl[i].tv);
      chk($sformatf("vec%0d cycle_count", i), cycle_count, tbl[i].cnt);
      chk($sformatf("vec%0d trace_pc", i), trace_pc, tbl[i].tpc);
    end

    // RUN for 10 cycles, HALT counted on its accept cycle, single REPORT.
    drive(1'b1, 8'h52, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (10) tick();
    chk("run10 cycle_count", cycle_count, 32'd10);
    drive(1'b1, 8'h48, 1'b0); tick();
    chk("run halt cycle_count", cycle_count, 32'd11);
    chk("run halt trace_valid", trace_valid, 1'b1);
    chk("run halt pipe_en", pipe_en, 1'b0);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("run done halted", halted, 1'b1);
    chk("run done trace_valid", trace_valid, 1'b0);
    repeat (3) tick();
    chk("run one report", trace_valid, 1'b0);
    chk("run final count", cycle_count, 32'd11);

    // REPORT stall with an 'S' waiting upstream.
    drive(1'b1, 8'h53, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    chk("stall enter trace_valid", trace_valid, 1'b1);
    pc = 32'h1234;
    drive(1'b1, 8'h53, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d trace_valid", i), trace_valid, 1'b1);
      chk($sformatf("stall%0d trace_pc", i), trace_pc, 32'h40);
      chk($sformatf("stall%0d cmd_ready", i), cmd_ready, 1'b0);
      chk($sformatf("stall%0d pipe_en", i), pipe_en, 1'b0);
    end
    drive(1'b1, 8'h53, 1'b1); tick();
    chk("stall release halted", halted, 1'b1);
    chk("stall S not taken", pipe_en, 1'b0);
    drive(1'b1, 8'h53, 1'b0); tick();
    chk("stall S taken pipe_en", pipe_en, 1'b1);
    chk("stall S taken halted", halted, 1'b0);
    drive(1'b0, 8'h00, 1'b0); tick();
    chk("stall step2 trace_pc", trace_pc, 32'h1234);
    chk("stall step2 count", cycle_count, 32'd13);
    drive(1'b0, 8'h00, 1'b1); tick();

    // Counter wrap, then clear in HALT.
    dut.u_cnt.count = 32'hFFFF_FFFE;
    drive(1'b1, 8'h52, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick(); tick();
    chk("wrap zero", cycle_count, 32'd0);
    drive(1'b1, 8'h48, 1'b0); tick();
    chk("wrap one", cycle_count, 32'd1);
    drive(1'b0, 8'h00, 1'b1); tick();
    drive(1'b1, 8'h43, 1'b0); tick();
    chk("clear count", cycle_count, 32'd0);

`ifdef DEBUG_BREAKPOINT_EN
    // Breakpoint at 0x20 while pc advances by 4 on each enabled cycle.
    pc = 32'h0; bp_addr = 32'h20; bp_enable = 1'b1; hit = 1'b0;
    drive(1'b1, 8'h52, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20 && !hit; i++) begin
      chk($sformatf("bp pc%0h pipe_en", pc), pipe_en, (pc != 32'h20));
      if (pc == 32'h20) hit = 1'b1;
      else begin tick(); pc = pc + 32'd4; end
    end
    chk("bp reached", hit, 1'b1);
    tick();
    chk("bp trace_valid", trace_valid, 1'b1);
    chk("bp trace_pc", trace_pc, 32'h20);
    chk("bp count", cycle_count, 32'd8);
    drive(1'b0, 8'h00, 1'b1); tick();
    drive(1'b1, 8'h53, 1'b0); tick();
    chk("bp ignored in step", pipe_en, 1'b1);
    drive(1'b0, 8'h00, 1'b1); tick(); tick();
    bp_enable = 1'b0;
`endif

    // Asynchronous reset mid-STEP on the 8-cycle instance.
    rst8_n = 1'b1;
    drive(1'b1, 8'h53, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();
    chk("step8 pipe_en", pipe_en8, 1'b1);
    chk("step8 count", cycle_count8, 32'd3);
    #2 rst8_n = 1'b0;
    #1;
    chk("arst halted", halted8, 1'b1);
    chk("arst pipe_en", pipe_en8, 1'b0);
    chk("arst trace_valid", trace_valid8, 1'b0);
    chk("arst count", cycle_count8, 32'd0);
    chk("arst cmd_ready", cmd_ready8, 1'b1);
    tick();
    rst8_n = 1'b1;
    repeat (10) tick();
    chk("arst no snapshot", trace_valid8, 1'b0);
    chk("arst stays halted", halted8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
